// File: rtl/cnn_fp16_pkg.sv
// Shared FP16 constants and the accumulator state encoding.
// Imported by the window accumulator and its testbench.
package cnn_fp16_pkg;

    localparam logic [15:0] FP16_ZERO = 16'h0000;
    localparam logic [15:0] FP16_ONE  = 16'h3C00;
    localparam logic [15:0] FP16_QNAN = 16'h7E00;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } accState_t;

endpackage

// File: rtl/floatAdd16.sv
// Combinational IEEE-754 half-precision adder, round-to-nearest-even.
// Ports: floatA, floatB (operands), sum (result).
module floatAdd16
    import cnn_fp16_pkg::*;
(
    input  logic [15:0] floatA,
    input  logic [15:0] floatB,
    output logic [15:0] sum
);

    logic        bigA;
    logic [15:0] x;
    logic [15:0] y;
    logic [4:0]  ex;
    logic [4:0]  ey;
    logic [4:0]  d;
    logic [13:0] mx;
    logic [13:0] my;
    logic [13:0] ones;
    logic [13:0] al;
    logic        stk;
    logic [14:0] s;
    logic [13:0] n;
    logic [5:0]  e;
    logic        rup;
    logic [11:0] r;

    always_comb begin
        // x always carries the larger magnitude, so it also owns the sign
        bigA = floatA[14:0] >= floatB[14:0];
        x    = bigA ? floatA : floatB;
        y    = bigA ? floatB : floatA;
        ex   = (x[14:10] == 5'd0) ? 5'd1 : x[14:10];
        ey   = (y[14:10] == 5'd0) ? 5'd1 : y[14:10];
        mx   = {x[14:10] != 5'd0, x[9:0], 3'b000};
        my   = {y[14:10] != 5'd0, y[9:0], 3'b000};
        d    = ex - ey;
        ones = '1;
        if (d >= 5'd14) begin
            al  = '0;
            stk = |my;
        end else begin
            al  = my >> d;
            stk = |(my & ~(ones << d));
        end
        al[0] = al[0] | stk;
        if (x[15] == y[15])
            s = {1'b0, mx} + {1'b0, al};
        else
            s = {1'b0, mx} - {1'b0, al};
        e = {1'b0, ex};
        if (s[14]) begin
            n = s[14:1] | {13'd0, s[0]};
            e = e + 6'd1;
        end else begin
            n = s[13:0];
            // stop at exponent 1 so tiny results stay subnormal
            for (int i = 0; i < 13; i++) begin
                if (!n[13] && e > 6'd1) begin
                    n = n << 1;
                    e = e - 6'd1;
                end
            end
        end
        rup = n[2] & (n[1] | n[0] | n[3]);
        r   = {1'b0, n[13:3]} + {11'd0, rup};
        if (r[11]) begin
            r = r >> 1;
            e = e + 6'd1;
        end
        if (x[14:10] == 5'h1F) begin
            if (x[9:0] != 10'd0 ||
                (y[14:10] == 5'h1F && x[15] != y[15]))
                sum = FP16_QNAN;
            else
                sum = x;
        end else if (s == 15'd0) begin
            sum = {x[15] & y[15], 15'd0};
        end else if (e >= 6'd31) begin
            sum = {x[15], 5'h1F, 10'd0};
        end else begin
            sum = {x[15], r[10] ? e[4:0] : 5'd0, r[9:0]};
        end
    end

endmodule

// File: rtl/float_accum16.sv
// Sums LEN FP16 terms per window and hands the result downstream.
// Ports: clk, rst_n, in_valid/in_ready/in_data, out_valid/out_ready/out_sum, busy.
module float_accum16 #(
    parameter int LEN = 9
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_sum,
    output logic        busy
);
    import cnn_fp16_pkg::*;

    localparam int CW = $clog2(LEN + 1);
    localparam logic [CW-1:0] LAST = CW'(LEN - 1);

    accState_t     state;
    accState_t     stateNext;
    logic [15:0]   acc;
    logic [15:0]   accNext;
    logic [15:0]   accSum;
    logic [CW-1:0] count;
    logic [CW-1:0] countNext;
    logic [15:0]   sumNext;
    logic          beat;

    floatAdd16 u_add (
        .floatA (acc),
        .floatB (in_data),
        .sum    (accSum)
    );

    assign in_ready  = (state != DONE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign beat      = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            acc     <= FP16_ZERO;
            count   <= '0;
            out_sum <= FP16_ZERO;
        end else begin
            state   <= stateNext;
            acc     <= accNext;
            count   <= countNext;
            out_sum <= sumNext;
        end
    end

    always_comb begin
        stateNext = state;
        accNext   = acc;
        countNext = count;
        sumNext   = out_sum;
        unique case (state)
            IDLE, ACC: begin
                if (beat) begin
                    accNext   = accSum;
                    countNext = count + CW'(1);
                    stateNext = ACC;
                    if (count == LAST) begin
                        sumNext   = accSum;
                        stateNext = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    stateNext = IDLE;
                    accNext   = FP16_ZERO;
                    countNext = '0;
                end
            end
            default: begin
                stateNext = IDLE;
                accNext   = FP16_ZERO;
                countNext = '0;
            end
        endcase
    end

endmodule
